// File: rtl/conv_acc_5x5.sv
// 5x5 valid convolution accelerator: produces two output rows per pass with 50 parallel MACs,
// fetching kernel rows and input words one per strobed cycle.
module conv_acc_5x5 #(
   parameter int out_data_width = 25,
   parameter int buf_addr_width = 5,
   parameter int buf_depth      = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start_conv,
   input  logic [1:0]                cfg_ci,
   input  logic [1:0]                cfg_co,
   input  logic [63:0]               ifm,
   input  logic [39:0]               weight,
   output logic [out_data_width-1:0] ofm_port0,
   output logic [out_data_width-1:0] ofm_port1,
   output logic                      ofm_port0_v,
   output logic                      ofm_port1_v,
   output logic                      ifm_read,
   output logic                      wgt_read,
   output logic                      end_conv
);

   localparam int IN_W = buf_depth + 4;
   localparam int WPR  = (IN_W + 7) / 8;
   localparam int ROWB = WPR * 8;
   localparam int WW   = $clog2(WPR);
   localparam int IW   = $clog2(ROWB);
   localparam int CW   = $clog2(buf_depth);
   localparam logic [buf_addr_width-1:0] COL_LAST = buf_addr_width'(buf_depth - 1);
   localparam logic [buf_addr_width-1:0] P_LAST   = buf_addr_width'(buf_depth / 2 - 1);
   localparam logic [WW-1:0]             WRD_LAST = WW'(WPR - 1);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] LD_W = 3'd1;
   localparam logic [2:0] LD_I = 3'd2;
   localparam logic [2:0] MAC  = 3'd3;
   localparam logic [2:0] OUT  = 3'd4;
   localparam logic [2:0] DONE = 3'd5;

   logic [2:0]                state_q, state_d;
   logic [2:0]                row_q, row_d;
   logic [WW-1:0]             wrd_q, wrd_d;
   logic [buf_addr_width-1:0] col_q, col_d;
   logic [buf_addr_width-1:0] p_q, p_d;
   logic [4:0]                ci_q, ci_d, co_q, co_d;
   logic [1:0]                cfg_ci_q, cfg_ci_d, cfg_co_q, cfg_co_d;

   logic [out_data_width-1:0] ofm0_q, ofm0_d, ofm1_q, ofm1_d;
   logic                      ofm_v_q, ofm_v_d;
   logic                      ifm_rd_q, wgt_rd_q, end_q;

   logic signed [7:0]                wbuf_q [0:4][0:4];
   logic signed [7:0]                ibuf_q [0:5][0:ROWB-1];
   logic signed [out_data_width-1:0] psum0_q [0:buf_depth-1];
   logic signed [out_data_width-1:0] psum1_q [0:buf_depth-1];
   logic signed [out_data_width-1:0] mac0, mac1;
   logic [IW-1:0]                    xi;
   logic [CW-1:0]                    col_idx;
   logic                             last_ci, last_co, psum_clr;

   // 16-bit signed product sign-extended to the accumulator width; overflow wraps.
   function automatic logic signed [out_data_width-1:0] ext_prod(input logic signed [7:0] a,
                                                                 input logic signed [7:0] b);
      logic signed [15:0] prod;
      prod = a * b;
      return out_data_width'(prod);
   endfunction

   assign last_ci  = (ci_q == {cfg_ci_q, 3'b111});
   assign last_co  = (co_q == {cfg_co_q, 3'b111});
   assign col_idx  = col_q[CW-1:0];
   assign psum_clr = ((state_q == IDLE) && start_conv) || ((state_q == OUT) && (col_q == COL_LAST));

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      wrd_d    = wrd_q;
      col_d    = col_q;
      p_d      = p_q;
      ci_d     = ci_q;
      co_d     = co_q;
      cfg_ci_d = cfg_ci_q;
      cfg_co_d = cfg_co_q;
      case (state_q)
         IDLE: if (start_conv) begin
            state_d  = LD_W;
            cfg_ci_d = cfg_ci;
            cfg_co_d = cfg_co;
            row_d    = '0;
            wrd_d    = '0;
            col_d    = '0;
            p_d      = '0;
            ci_d     = '0;
            co_d     = '0;
         end
         LD_W: if (row_q == 3'd4) begin
            row_d   = '0;
            state_d = LD_I;
         end else begin
            row_d = row_q + 3'd1;
         end
         LD_I: if (wrd_q == WRD_LAST) begin
            wrd_d = '0;
            if (row_q == 3'd5) begin
               row_d   = '0;
               state_d = MAC;
            end else begin
               row_d = row_q + 3'd1;
            end
         end else begin
            wrd_d = wrd_q + WW'(1);
         end
         MAC: if (col_q == COL_LAST) begin
            col_d = '0;
            if (last_ci) begin
               ci_d    = '0;
               state_d = OUT;
            end else begin
               ci_d    = ci_q + 5'd1;
               state_d = LD_W;
            end
         end else begin
            col_d = col_q + buf_addr_width'(1);
         end
         OUT: if (col_q == COL_LAST) begin
            col_d = '0;
            if (last_co) begin
               co_d = '0;
               if (p_q == P_LAST) begin
                  state_d = DONE;
               end else begin
                  p_d     = p_q + buf_addr_width'(1);
                  state_d = LD_W;
               end
            end else begin
               co_d    = co_q + 5'd1;
               state_d = LD_W;
            end
         end else begin
            col_d = col_q + buf_addr_width'(1);
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the cycle the FSM is in.
   always_comb begin
      ofm_v_d = (state_d == OUT);
      ofm0_d  = ofm_v_d ? psum0_q[col_d[CW-1:0]] : '0;
      ofm1_d  = ofm_v_d ? psum1_q[col_d[CW-1:0]] : '0;
   end

   always_comb begin
      mac0 = '0;
      mac1 = '0;
      xi   = '0;
      for (int kc = 0; kc < 5; kc++) begin
         xi = IW'(col_q) + IW'(kc);
         for (int kr = 0; kr < 5; kr++) begin
            mac0 = mac0 + ext_prod(wbuf_q[kr][kc], ibuf_q[kr][xi]);
            mac1 = mac1 + ext_prod(wbuf_q[kr][kc], ibuf_q[kr+1][xi]);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         row_q    <= '0;
         wrd_q    <= '0;
         col_q    <= '0;
         p_q      <= '0;
         ci_q     <= '0;
         co_q     <= '0;
         cfg_ci_q <= '0;
         cfg_co_q <= '0;
         ofm0_q   <= '0;
         ofm1_q   <= '0;
         ofm_v_q  <= 1'b0;
         ifm_rd_q <= 1'b0;
         wgt_rd_q <= 1'b0;
         end_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         wrd_q    <= wrd_d;
         col_q    <= col_d;
         p_q      <= p_d;
         ci_q     <= ci_d;
         co_q     <= co_d;
         cfg_ci_q <= cfg_ci_d;
         cfg_co_q <= cfg_co_d;
         ofm0_q   <= ofm0_d;
         ofm1_q   <= ofm1_d;
         ofm_v_q  <= ofm_v_d;
         ifm_rd_q <= (state_d == LD_I);
         wgt_rd_q <= (state_d == LD_W);
         end_q    <= (state_d == DONE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < buf_depth; i++) begin
            psum0_q[i] <= '0;
            psum1_q[i] <= '0;
         end
      end else if (psum_clr) begin
         for (int i = 0; i < buf_depth; i++) begin
            psum0_q[i] <= '0;
            psum1_q[i] <= '0;
         end
      end else if (state_q == MAC) begin
         psum0_q[col_idx] <= psum0_q[col_idx] + mac0;
         psum1_q[col_idx] <= psum1_q[col_idx] + mac1;
      end
   end

   // Fetch buffers hold no state worth resetting; they are always reloaded before use.
   always_ff @(posedge clk) begin
      if (state_q == LD_W) begin
         for (int k = 0; k < 5; k++) wbuf_q[row_q][k] <= weight[8*k +: 8];
      end
      if (state_q == LD_I) begin
         for (int j = 0; j < 8; j++) ibuf_q[row_q][{wrd_q, 3'(j)}] <= ifm[8*j +: 8];
      end
   end

   assign ofm_port0   = ofm0_q;
   assign ofm_port1   = ofm1_q;
   assign ofm_port0_v = ofm_v_q;
   assign ofm_port1_v = ofm_v_q;
   assign ifm_read    = ifm_rd_q;
   assign wgt_read    = wgt_rd_q;
   assign end_conv    = end_q;

endmodule

// File: tb/tb_conv_acc_5x5.sv
// Bench for conv_acc_5x5: feeds a full input tile and weight set on the read strobes and
// compares the output stream against a direct convolution of those arrays.
module tb_conv_acc_5x5;

   localparam int D    = 16;
   localparam int OW   = 25;
   localparam int IN_W = 20;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 start_conv = 1'b0;
   logic [1:0]           cfg_ci = '0;
   logic [1:0]           cfg_co = '0;
   logic [63:0]          ifm = '0;
   logic [39:0]          weight = '0;
   logic signed [OW-1:0] ofm0, ofm1;
   logic                 v0, v1, ifm_read, wgt_read, end_conv;

   conv_acc_5x5 #(.out_data_width(OW), .buf_addr_width(5), .buf_depth(D)) dut (
      .clk(clk), .rst_n(rst_n), .start_conv(start_conv), .cfg_ci(cfg_ci), .cfg_co(cfg_co),
      .ifm(ifm), .weight(weight), .ofm_port0(ofm0), .ofm_port1(ofm1),
      .ofm_port0_v(v0), .ofm_port1_v(v1), .ifm_read(ifm_read), .wgt_read(wgt_read),
      .end_conv(end_conv)
   );

   always #5 clk = ~clk;

   int  n_tests = 0;
   int  n_fail  = 0;
   byte in_t [0:31][0:IN_W-1][0:IN_W-1];
   byte w_t  [0:31][0:31][0:4][0:4];
   byte fill = 8'sh5A;
   int  ci_n = 8, co_n = 8;
   int  w_idx = 0, i_idx = 0;
   logic clr_idx = 1'b0;

   int q0[$], q1[$];
   int n_vbad, n_end, n_wr, n_ir, n_both, run_cyc;
   bit timed_out;

   // Word counters: index of the next word the DUT will consume on each stream.
   always @(posedge clk) begin
      if (clr_idx) begin
         w_idx <= 0;
         i_idx <= 0;
      end else begin
         if (wgt_read) w_idx <= w_idx + 1;
         if (ifm_read) i_idx <= i_idx + 1;
      end
   end

   // Present the word for the current index; the loop order is p, co, ci, then row/word.
   always @(negedge clk) begin : drv
      int t, kr, ci, co, wd, row, p, y, x;
      kr = w_idx % 5;
      t  = w_idx / 5;
      ci = t % ci_n;
      co = (t / ci_n) % co_n;
      for (int k = 0; k < 5; k++) weight[8*k +: 8] = w_t[co][ci][kr][k];
      wd  = i_idx % 3;
      row = (i_idx / 3) % 6;
      t   = i_idx / 18;
      ci  = t % ci_n;
      p   = t / (ci_n * co_n);
      y   = 2 * p + row;
      for (int j = 0; j < 8; j++) begin
         x = 8 * wd + j;
         ifm[8*j +: 8] = (y < IN_W && x < IN_W) ? in_t[ci][y][x] : fill;
      end
   end

   function automatic int ref_out(int co, int r, int c);
      int s;
      logic signed [OW-1:0] t;
      s = 0;
      for (int ci = 0; ci < ci_n; ci++)
         for (int kr = 0; kr < 5; kr++)
            for (int kc = 0; kc < 5; kc++)
               s += int'(in_t[ci][r+kr][c+kc]) * int'(w_t[co][ci][kr][kc]);
      t = OW'(s);
      return int'(t);
   endfunction

   // Runs one convolution and records what came out; comparisons are made by the callers.
   task automatic run_conv(input logic [1:0] ci, input logic [1:0] co, input int busy_at,
                           input int stop_at);
      int cyc;
      q0.delete();
      q1.delete();
      n_vbad = 0; n_end = 0; n_wr = 0; n_ir = 0; n_both = 0; run_cyc = -1; timed_out = 0;
      ci_n = (int'(ci) + 1) * 8;
      co_n = (int'(co) + 1) * 8;
      @(negedge clk);
      clr_idx = 1'b1; cfg_ci = ci; cfg_co = co; start_conv = 1'b1;
      @(negedge clk);
      clr_idx = 1'b0; start_conv = 1'b0; cfg_ci = 2'd3; cfg_co = 2'd3;
      cyc = 1;
      forever begin
         if (v0 !== v1 || (!v0 && (ofm0 !== '0 || ofm1 !== '0))) n_vbad++;
         if (v0 === 1'b1) begin
            q0.push_back(int'(ofm0));
            q1.push_back(int'(ofm1));
         end
         if (wgt_read === 1'b1) n_wr++;
         if (ifm_read === 1'b1) n_ir++;
         if (wgt_read === 1'b1 && ifm_read === 1'b1) n_both++;
         if (end_conv === 1'b1) begin
            n_end++;
            if (run_cyc < 0) run_cyc = cyc - 1;
         end
         if (stop_at > 0 && cyc == stop_at) break;
         if (run_cyc >= 0 && cyc >= run_cyc + 6) break;
         if (cyc >= 45000) begin
            timed_out = 1;
            break;
         end
         start_conv = (cyc == busy_at);
         @(negedge clk);
         cyc++;
      end
      start_conv = 1'b0;
   endtask

   task automatic test_reset();
      int act;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({ofm0, ofm1, v0, v1, ifm_read, wgt_read, end_conv} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h, expected 0", {ofm0, ofm1, v0, v1, ifm_read, wgt_read, end_conv});
      end
      rst_n = 1'b1;
      act = 0;
      repeat (4) begin
         @(negedge clk);
         if (ifm_read !== 1'b0 || wgt_read !== 1'b0 || end_conv !== 1'b0 || v0 !== 1'b0) act++;
      end
      n_tests++;
      if (act !== 0) begin
         n_fail++;
         $display("FAIL idle_after_reset: got %0d active cycles, expected 0", act);
      end
   endtask

   task automatic test_random_abort();
      int bad, first, p, co, c, act;
      fill = byte'($urandom);
      for (int a = 0; a < 8; a++)
         for (int y = 0; y < IN_W; y++)
            for (int x = 0; x < IN_W; x++) in_t[a][y][x] = byte'($urandom);
      for (int o = 0; o < 8; o++)
         for (int a = 0; a < 8; a++)
            for (int r = 0; r < 5; r++)
               for (int k = 0; k < 5; k++) w_t[o][a][r][k] = byte'($urandom);
      run_conv(2'd0, 2'd0, 0, 2635);
      n_tests++;
      if (q0.size() != 128) begin
         n_fail++;
         $display("FAIL rand_p0_count: got %0d, expected 128", q0.size());
      end
      bad = 0; first = -1;
      for (int n = 0; n < q0.size() && n < 128; n++) begin
         p = n / (co_n * D); co = (n / D) % co_n; c = n % D;
         if (q0[n] != ref_out(co, 2*p, c) || q1[n] != ref_out(co, 2*p+1, c)) begin
            bad++;
            if (first < 0) first = n;
         end
      end
      n_tests++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL rand_values: got %0d wrong (first idx %0d: %0d/%0d), expected 0 wrong",
                  bad, first, q0[first], q1[first]);
      end
      n_tests++;
      if (ifm_read !== 1'b1 || n_vbad !== 0) begin
         n_fail++;
         $display("FAIL rand_ld_i_state: got ifm_read=%b vbad=%0d, expected 1 and 0", ifm_read, n_vbad);
      end
      #1 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({ofm0, ofm1, v0, v1, ifm_read, wgt_read, end_conv} !== '0) begin
         n_fail++;
         $display("FAIL async_reset_outputs: got %h, expected 0", {ofm0, ofm1, v0, v1, ifm_read, wgt_read, end_conv});
      end
      act = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (end_conv !== 1'b0 || ifm_read !== 1'b0 || wgt_read !== 1'b0) act++;
      end
      n_tests++;
      if (act !== 0) begin
         n_fail++;
         $display("FAIL abort_quiet: got %0d active cycles, expected 0", act);
      end
   endtask

   task automatic test_identity();
      int bad, first, p, c;
      for (int a = 0; a < 8; a++)
         for (int y = 0; y < IN_W; y++)
            for (int x = 0; x < IN_W; x++) in_t[a][y][x] = (a == 0) ? byte'(y + x) : byte'($urandom);
      for (int o = 0; o < 8; o++)
         for (int a = 0; a < 8; a++)
            for (int r = 0; r < 5; r++)
               for (int k = 0; k < 5; k++) w_t[o][a][r][k] = (a == 0 && r == 2 && k == 2) ? 8'sd1 : 8'sd0;
      run_conv(2'd0, 2'd0, 0, 0);
      n_tests++;
      if (timed_out || n_end !== 1 || q0.size() != 1024) begin
         n_fail++;
         $display("FAIL ident_run: got end=%0d outs=%0d timeout=%0d, expected 1 1024 0", n_end, q0.size(), timed_out);
      end
      bad = 0; first = -1;
      for (int n = 0; n < q0.size(); n++) begin
         p = n / (co_n * D); c = n % D;
         if (q0[n] != 2*p + c + 4 || q1[n] != 2*p + 1 + c + 4) begin
            bad++;
            if (first < 0) first = n;
         end
      end
      n_tests++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL ident_values: got %0d wrong (first idx %0d), expected 0 wrong", bad, first);
      end
      if (q0.size() > 389) begin
         n_tests++;
         if (q0[389] !== 15 || q1[389] !== 16) begin
            n_fail++;
            $display("FAIL ident_p3_c5: got %0d/%0d, expected 15/16", q0[389], q1[389]);
         end
      end
   endtask

   task automatic test_all_ones_busy();
      int bad;
      fill = 8'sh7F;
      for (int a = 0; a < 8; a++)
         for (int y = 0; y < IN_W; y++)
            for (int x = 0; x < IN_W; x++) in_t[a][y][x] = 8'sd1;
      for (int o = 0; o < 8; o++)
         for (int a = 0; a < 8; a++)
            for (int r = 0; r < 5; r++)
               for (int k = 0; k < 5; k++) w_t[o][a][r][k] = 8'sd1;
      run_conv(2'd0, 2'd0, 1000, 0);
      bad = 0;
      foreach (q0[n]) if (q0[n] != 200 || q1[n] != 200) bad++;
      n_tests++;
      if (bad !== 0 || q0.size() != 1024) begin
         n_fail++;
         $display("FAIL ones_values: got %0d wrong of %0d, expected 0 of 1024", bad, q0.size());
      end
      n_tests++;
      if (n_vbad !== 0 || n_both !== 0) begin
         n_fail++;
         $display("FAIL ones_valid_pairing: got vbad=%0d both_strobes=%0d, expected 0 0", n_vbad, n_both);
      end
      n_tests++;
      if (n_end !== 1 || timed_out) begin
         n_fail++;
         $display("FAIL ones_end_conv: got %0d pulses timeout=%0d, expected 1 0", n_end, timed_out);
      end
      n_tests++;
      if (n_wr !== 2560 || n_ir !== 9216) begin
         n_fail++;
         $display("FAIL ones_strobe_counts: got wgt=%0d ifm=%0d, expected 2560 9216", n_wr, n_ir);
      end
      n_tests++;
      if (run_cyc !== 20992) begin
         n_fail++;
         $display("FAIL ones_run_length: got %0d, expected 20992", run_cyc);
      end
   endtask

   task automatic test_neg_two_ci();
      int bad;
      for (int a = 0; a < 16; a++)
         for (int y = 0; y < IN_W; y++)
            for (int x = 0; x < IN_W; x++) in_t[a][y][x] = -8'sd1;
      for (int o = 0; o < 8; o++)
         for (int a = 0; a < 16; a++)
            for (int r = 0; r < 5; r++)
               for (int k = 0; k < 5; k++) w_t[o][a][r][k] = 8'sd2;
      run_conv(2'd1, 2'd0, 0, 0);
      bad = 0;
      foreach (q0[n]) if (q0[n] != -800 || q1[n] != -800) bad++;
      n_tests++;
      if (bad !== 0 || q0.size() != 1024) begin
         n_fail++;
         $display("FAIL neg_values: got %0d wrong of %0d, expected 0 of 1024", bad, q0.size());
      end
      n_tests++;
      if (n_end !== 1 || n_wr !== 5120) begin
         n_fail++;
         $display("FAIL neg_run: got end=%0d wgt=%0d, expected 1 5120", n_end, n_wr);
      end
   endtask

   initial begin
      test_reset();
      test_random_abort();
      test_identity();
      test_all_ones_busy();
      test_neg_two_ci();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/conv_acc_5x5.md
CONV_ACC_5X5 -- requirements
Module: conv_acc_5x5

Interface
REQ-001 SHALL have parameters: out_data_width, default 25, output word width; buf_addr_width, default 5, column counter width (must be at least clog2(buf_depth+4)); buf_depth, default 16, output tile width and height in pixels.
REQ-002 SHALL have ports, in this order:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- start_conv, input, 1: one-cycle start pulse.
- cfg_ci, input, 2: input channels CI_N = (cfg_ci+1)*8.
- cfg_co, input, 2: output channels CO_N = (cfg_co+1)*8.
- ifm, input, 64: 8 signed 8-bit pixels; byte j = column 8w+j of word w.
- weight, input, 40: 5 signed 8-bit taps of one kernel row; byte k = kernel column k.
- ofm_port0, output, out_data_width: signed result for row 2p.
- ofm_port1, output, out_data_width: signed result for row 2p+1.
- ofm_port0_v, ofm_port1_v, output, 1 each: output valids.
- ifm_read, wgt_read, output, 1 each: fetch strobes.
- end_conv, output, 1: one-cycle done pulse.
REQ-003 SHALL treat ifm/weight as combinationally valid in the same cycle its read strobe is high; one word consumed per high cycle; never assert both strobes in one cycle.

Function
REQ-004 SHALL compute a valid 5x5 convolution (stride 1, no padding) of a (buf_depth+4)x(buf_depth+4) input tile per channel: out[co][r][c] = sum over ci, kr, kc of in[ci][r+kr][c+kc]*w[co][ci][kr][kc], with r, c in 0..buf_depth-1.
REQ-005 SHALL use signed 8x8 products (16 bits), sign-extended and accumulated at out_data_width bits, wrapping on overflow.
REQ-006 SHALL latch cfg_ci and cfg_co on an accepted start_conv; start_conv SHALL be ignored unless in IDLE.
REQ-007 SHALL use loop order: row pair p = 0..buf_depth/2-1 (outer), co = 0..CO_N-1, ci = 0..CI_N-1 (inner).
REQ-008 SHALL have FSM states IDLE, LD_W, LD_I, MAC, OUT, DONE.
REQ-009 IDLE: on start_conv go to LD_W next cycle and clear the 2 x buf_depth partial-sum registers.
REQ-010 LD_W: 5 consecutive cycles with wgt_read=1, loading kernel rows kr = 0..4 for (co, ci).
REQ-011 LD_I: 18 consecutive cycles with ifm_read=1, loading input rows 2p..2p+5 for ci at 3 words per row; bytes for columns 20..23 are ignored.
REQ-012 MAC: buf_depth cycles, one column c per cycle, 50 parallel MACs update psum0[c] and psum1[c]; then go to LD_W for the next ci, or to OUT after the last ci.
REQ-013 OUT: buf_depth consecutive cycles, c = 0..buf_depth-1, with ofm_port0 = psum0[c], ofm_port1 = psum1[c] and both valids = 1; then clear psums and go to LD_W, or to DONE after the last co and last p.
REQ-014 DONE: end_conv = 1 for exactly one cycle, then IDLE.
REQ-015 ofm ports SHALL be 0 whenever their valid is 0; all outputs SHALL be registered.

Reset
REQ-016 rst_n low SHALL immediately force IDLE; all outputs 0; psums, counters and latched cfg cleared.
REQ-017 Reset mid-operation SHALL abort without an end_conv pulse; a new start_conv after release SHALL restart from p = 0.

Verification
REQ-018 Reset: assert rst_n=0 at any time -> all outputs 0 within the same cycle; after release, IDLE with no strobes.
REQ-019 cfg 0/0, all ifm bytes = 1, all weight bytes = 1:
- every ofm_port0/1 value = 200;
- 1024 valid cycles (8 p x 8 co x 16), both valids always high together;
- exactly one end_conv.
REQ-020 cfg 0/0 strobe counts: wgt_read high 2560 cycles; ifm_read high 9216 cycles; total run 20992 cycles from start to end_conv.
REQ-021 cfg_ci=1, ifm bytes = 0xFF (-1), weights = 2 -> every output = -800.
REQ-022 Identity kernel (only kr=2, kc=2 tap = 1, ci=0 only), in[0][y][x] = y+x -> out[r][c] = r+c+4, e.g. p=3, c=5 gives port0 = 15 and port1 = 16.
REQ-023 start_conv pulsed while busy -> ignored: read counts and the single end_conv match REQ-020; reset during LD_I -> strobes drop, no end_conv.
